// File: rtl/mult_pkg.sv
// Shared types and mod-3 helpers for the sequential multiplier with residue check.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;

    localparam int MAX_WIDTH = 32;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    // A 2-bit group b1*2+b0 is congruent to b0-b1 mod 3, so only the value 3 folds to 0.
    function automatic logic [1:0] fold2(input logic [1:0] x);
        return (x == 2'd3) ? 2'd0 : x;
    endfunction

    function automatic logic [1:0] mod3_add(input logic [1:0] r1, input logic [1:0] r2);
        logic [2:0] s;
        s = {1'b0, r1} + {1'b0, r2};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [1:0] mod3_mul(input logic [1:0] r1, input logic [1:0] r2);
        logic [3:0] p;
        p = {2'b00, r1} * {2'b00, r2};
        return mod3_add(fold2(p[1:0]), fold2(p[3:2]));
    endfunction

endpackage

// File: rtl/mod3_residue.sv
// Combinational N-bit value -> residue mod 3, as a balanced tree over 2-bit groups.
module mod3_residue
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] x_i,
    output logic [1:0]   r_o
);

    localparam int NP = (N + 1) / 2;
    localparam int LP = 2 ** $clog2(NP);
    localparam int PW = 2 * LP;

    logic [PW-1:0] x_pad;

    assign x_pad = PW'(x_i);

    // Groups carry weight 4^k == 1 (mod 3), so their residues simply add up the tree.
    always_comb begin
        logic [1:0] node [2*LP];
        for (int i = 0; i < 2 * LP; i++) begin
            node[i] = 2'd0;
        end
        for (int i = 0; i < LP; i++) begin
            node[LP + i] = fold2(x_pad[2*i +: 2]);
        end
        for (int i = LP - 1; i >= 1; i--) begin
            node[i] = mod3_add(node[2*i], node[2*i + 1]);
        end
        r_o = node[1];
    end

endmodule

// File: rtl/mult_seq_resid_chk.sv
// Radix-2 shift-add WIDTH x WIDTH multiplier, signed or unsigned per transaction,
// with a mod-3 residue check on every product.
//   state | meaning
//   IDLE  | ready for operands, capture magnitudes/sign/residues on handshake
//   RUN   | one shift-add step per cycle, WIDTH cycles
//   CHECK | residue compare and sign fix-up into output registers
//   DONE  | result valid, held until the consumer accepts
module mult_seq_resid_chk
    import mult_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    input  logic                 in_signed_i,
    input  logic                 err_inject_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_p_o,
    output logic                 res_err_o
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mult_q, mult_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 neg_q, neg_d;
    logic [1:0]           ra_q, ra_d;
    logic [1:0]           rb_q, rb_d;
    logic [2*WIDTH-1:0]   out_p_q, out_p_d;
    logic                 res_err_q, res_err_d;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [1:0]           ra_in, rb_in, rp;
    logic [WIDTH:0]       addend, sum;
    logic [WIDTH:0]       shift_acc;
    logic [WIDTH-1:0]     shift_mult;
    logic [2*WIDTH-1:0]   prod_mag, prod_signed;
    logic                 last_run;

    assign abs_a = (in_signed_i & in_a_i[WIDTH-1]) ? (~in_a_i + WIDTH'(1)) : in_a_i;
    assign abs_b = (in_signed_i & in_b_i[WIDTH-1]) ? (~in_b_i + WIDTH'(1)) : in_b_i;

    mod3_residue #(.N(WIDTH)) u_res_a (.x_i(abs_a), .r_o(ra_in));
    mod3_residue #(.N(WIDTH)) u_res_b (.x_i(abs_b), .r_o(rb_in));

    assign addend     = mult_q[0] ? {1'b0, mcand_q} : '0;
    assign sum        = acc_q + addend;
    assign shift_acc  = {1'b0, sum[WIDTH:1]};
    assign shift_mult = {sum[0], mult_q[WIDTH-1:1]};
    assign last_run   = (count_q == CNT_W'(1));

    assign prod_mag    = {acc_q[WIDTH-1:0], mult_q};
    assign prod_signed = neg_q ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;

    mod3_residue #(.N(2*WIDTH)) u_res_p (.x_i(prod_mag), .r_o(rp));

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_d     = neg_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        out_p_d   = out_p_q;
        res_err_d = res_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    mcand_d = abs_a;
                    mult_d  = abs_b;
                    acc_d   = '0;
                    neg_d   = in_signed_i & (in_a_i[WIDTH-1] ^ in_b_i[WIDTH-1]);
                    ra_d    = ra_in;
                    rb_d    = rb_in;
                    count_d = CNT_W'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                // {acc,mult} is one shift register; its bit 0 is the product LSB.
                acc_d   = shift_acc;
                mult_d  = {shift_mult[WIDTH-1:1], shift_mult[0] ^ (err_inject_i & last_run)};
                count_d = count_q - CNT_W'(1);
                if (last_run) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                out_p_d   = prod_signed;
                res_err_d = CHECK_EN & (rp != mod3_mul(ra_q, rb_q));
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            ra_q      <= 2'd0;
            rb_q      <= 2'd0;
            out_p_q   <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            out_p_q   <= out_p_d;
            res_err_q <= res_err_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign out_p_o     = out_p_q;
    assign res_err_o   = res_err_q;

endmodule
